// File: rtl/result_writer.sv
// rtl/result_writer.sv - packs value/repeat-count pairs into a result memory with header word.
// Optional running checksum of stored words: define RESULT_WRITER_CHECKSUM_EN.
module result_writer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rep_valid,
  input  logic [DATA_W-1:0] rep_count,
  input  logic              in_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pair_cnt,
  output logic              overflow,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int                MAX_PAIRS   = (DEPTH - 1) / 2;
  localparam logic [DATA_W-1:0] MAX_PAIRS_W = DATA_W'(MAX_PAIRS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HEADER, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              pending, pending_nxt;
  logic [DATA_W-1:0] pair_cnt_nxt;
  logic              overflow_nxt, err_nxt;
  logic              val_we, cnt_we, hdr_we, run_start;
  logic [ADDR_W-1:0] val_addr, cnt_addr;
  logic              full;

  // Value of pair n lives at 2n+1, its count at 2n+2; word 0 is the header.
  assign val_addr = ADDR_W'({pair_cnt, 1'b1});
  assign cnt_addr = val_addr + ADDR_W'(1);
  assign full     = (pair_cnt == MAX_PAIRS_W);
  assign busy     = (state == S_COLLECT) || (state == S_HEADER);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt    = state;
    pair_cnt_nxt = pair_cnt;
    pending_nxt  = pending;
    overflow_nxt = overflow;
    err_nxt      = err;
    val_we       = 1'b0;
    cnt_we       = 1'b0;
    hdr_we       = 1'b0;
    run_start    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          run_start    = 1'b1;
          state_nxt    = S_COLLECT;
          pair_cnt_nxt = '0;
          pending_nxt  = 1'b0;
          overflow_nxt = 1'b0;
          err_nxt      = 1'b0;
        end
      end
      S_COLLECT: begin
        // Pending is tracked even when full so a dropped pair raises no ordering error.
        if (in_valid) begin
          if (pending && !rep_valid) err_nxt = 1'b1;
          if (full) overflow_nxt = 1'b1;
          else      val_we       = 1'b1;
          pending_nxt = 1'b1;
        end
        if (rep_valid) begin
          if (pending || in_valid) begin
            if (!full) begin
              cnt_we       = 1'b1;
              pair_cnt_nxt = pair_cnt + DATA_W'(1);
            end
            pending_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        if (in_done) begin
          if (pending_nxt) err_nxt = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = S_HEADER;
        end
      end
      S_HEADER: begin
        hdr_we    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pair_cnt <= '0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pair_cnt <= pair_cnt_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      err      <= err_nxt;
    end
  end

  // Result storage is deliberately left out of reset so results survive a reset.
  always_ff @(posedge clk) begin
    if (val_we) mem[val_addr] <= in_data;
    if (cnt_we) mem[cnt_addr] <= rep_count;
    if (hdr_we) mem[0]        <= pair_cnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_nxt;

  always_comb begin
    sum_nxt = sum_q;
    if (run_start) begin
      sum_nxt = '0;
    end else begin
      if (val_we) sum_nxt = sum_nxt + in_data;
      if (cnt_we) sum_nxt = sum_nxt + rep_count;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sum_q <= '0;
    else         sum_q <= sum_nxt;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Downstream sink for the repeat-analysis core.
- Consumes its per-value stream (valid + data_out) and per-value repeat count (repeats_valid + repeats).
- Packs results into an internal result memory using the same layout as the input memory:
  - word 0: number of pairs;
  - then alternating value / repeat-count words.
- Provides a registered read-back port for the host or bench, plus done/error status.

Parameters:
- DATA_W, 8, width of values, counts and memory words.
- DEPTH, 256, result memory words; pair capacity MAX_PAIRS = (DEPTH-1)/2 (127 at default).
- ADDR_W, 8, address width; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new collection run.
- in_valid  in  1  in_data carries a new value this cycle.
- in_data  in  DATA_W  value from the core.
- rep_valid  in  1  rep_count carries the repeat count for the pending value.
- rep_count  in  DATA_W  repeat count.
- in_done  in  1  upstream finished; no further input this run.
- rd_addr  in  ADDR_W  read-back address.
- rd_data  out  DATA_W  mem[rd_addr], registered, 1-cycle latency.
- busy  out  1  high in COLLECT and HEADER.
- done  out  1  one-cycle pulse when the header word has been written.
- pair_cnt  out  DATA_W  pairs stored so far this run.
- overflow  out  1  sticky; a pair was dropped because memory was full.
- err  out  1  sticky; handshake ordering violation.
- checksum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0.
  - State IDLE; pending flag cleared.
  - Memory contents are not reset.
- States:
  - IDLE: start -> COLLECT. On that start edge: clear pair_cnt, overflow, err, pending and checksum. start outside IDLE is ignored.
  - COLLECT: accepts input. in_done -> HEADER.
  - HEADER: writes mem[0] = pair_cnt -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Timing of a run end: in_done sampled at edge T; mem[0] written at edge T+1; done high for the cycle after edge T+1.
- Pairing rules (COLLECT only; inputs ignored in every other state):
  - in_valid: store in_data at mem[2*pair_cnt+1] and set pending.
  - rep_valid with pending, or with in_valid in the same cycle: store rep_count at mem[2*pair_cnt+2], clear pending, increment pair_cnt.
  - Same-cycle in_valid+rep_valid writes both words on one edge (storage is a register array, so dual write is legal).
  - in_valid while pending and no rep_valid: err=1. The new value overwrites the old pending one at the same address; pair_cnt is unchanged.
  - rep_valid with no pending and no in_valid: err=1, count ignored.
  - in_done while pending: pending value discarded (not counted), err=1.
  - in_done in the same cycle as in_valid/rep_valid: those inputs are processed first, then in_done is applied to the result.
- Full: when pair_cnt == MAX_PAIRS, further values and counts are not written and pair_cnt holds. overflow=1 on the first dropped value.
- Arithmetic:
  - Addresses computed in ADDR_W bits.
  - pair_cnt never exceeds MAX_PAIRS, so no wrap.
  - rep_count is stored unmodified (0 is legal).
- Read port: rd_data is updated every cycle in every state, including IDLE and during a run. Same-cycle write/read returns the old data.
- Reset mid-run: returns to IDLE immediately. mem[0] keeps its previous value; done does not pulse.

Optional Feature:
- Macro: RESULT_WRITER_CHECKSUM_EN.
- Defined: checksum = sum mod 2**DATA_W of every stored value and count word this run, excluding mem[0].
  - Updated on the same edge as the corresponding write.
  - Cleared on start and on reset.
  - Holds after done.
- Undefined: no accumulator logic is built; checksum is tied to 0.

Test Plan:
- Nominal run: start, then 120 pairs (value i, count 1) for i=1..120, one per cycle with in_valid and rep_valid together, then in_done. Required: mem[0]=120, mem[1]=1, mem[2]=1, mem[239]=120, mem[240]=1; done pulses once, 2 edges after in_done; err=0, overflow=0.
- Split handshake: value 7 in one cycle, count 3 two cycles later, then value 9 with count 0 in the same cycle. Required: pair_cnt=2, mem[1..4]=7,3,9,0.
- Overflow: 130 pairs at DEPTH=256. Required: pair_cnt=127, overflow=1, mem[0]=127, mem[254]=count of pair 127, mem[255] unchanged.
- Protocol errors:
  - rep_valid first, then two in_valid (5, then 6) without a count, then in_done. Required: err=1, pair_cnt=0, mem[1]=6, mem[0]=0.
  - Alternative sequence: value 4 pending at in_done. Required: err=1, value not counted.
- Reset mid-run: after 10 pairs, resetn low for 2 cycles. Required: all outputs 0, no done pulse. A following full run behaves exactly as the nominal scenario.
- With RESULT_WRITER_CHECKSUM_EN defined, pairs (200,100), (1,2), (3,4). Required: checksum = 310 mod 256 = 54, holding after done. With the macro undefined: checksum=0 throughout.
